// File: rtl/zuc_pkg.sv
// zuc_pkg: word widths and the EMPTY/HI/LO state encoding shared by the ZUC
// width converters.
package zuc_pkg;

    localparam int ZUC_WORD_W  = 32;
    localparam int ZUC_DWORD_W = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HI    = 2'd1,
        LO    = 2'd2
    } zuc_dwd_state_t;

endpackage

// File: rtl/zuc_dw_down.sv
// zuc_dw_down: 64-bit to 32-bit stream downsizer, upper word first, one word per cycle.
// Optional ZUC_DWD_ODD_EN adds s_half so a final beat may carry only its upper word.
module zuc_dw_down
    import zuc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   s_last,
    input  logic [ZUC_DWORD_W-1:0] s_data,
`ifdef ZUC_DWD_ODD_EN
    input  logic                   s_half,
`endif
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic [ZUC_WORD_W-1:0]  m_data
);

    zuc_dwd_state_t         r_state;
    zuc_dwd_state_t         w_state_next;
    logic [ZUC_DWORD_W-1:0] r_data;
    logic                   r_last;
    logic                   w_in_hs;
    logic                   w_hi_final;

    assign w_in_hs = s_valid && s_ready;

`ifdef ZUC_DWD_ODD_EN
    logic r_half;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_half <= 1'b0;
        end else if (w_in_hs) begin
            r_half <= s_half;
        end
    end

    // A final half beat ends the message on its upper word.
    assign w_hi_final = r_last && r_half;
`else
    assign w_hi_final = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_in_hs) begin
                r_data <= s_data;
                r_last <= s_last;
            end
        end
    end

    // s_ready only opens when the held beat is empty or its final word leaves
    // this cycle, so a new beat never overwrites a word still being presented.
    always_comb begin
        w_state_next = r_state;
        s_ready      = 1'b0;
        m_valid      = (r_state != EMPTY);
        m_last       = 1'b0;
        m_data       = '0;
        case (r_state)
            EMPTY: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    w_state_next = HI;
                end
            end
            HI: begin
                m_data  = r_data[ZUC_DWORD_W-1:ZUC_WORD_W];
                m_last  = w_hi_final;
                s_ready = w_hi_final && m_ready;
                if (m_ready) begin
                    if (!w_hi_final) begin
                        w_state_next = LO;
                    end else if (s_valid) begin
                        w_state_next = HI;
                    end else begin
                        w_state_next = EMPTY;
                    end
                end
            end
            LO: begin
                m_data  = r_data[ZUC_WORD_W-1:0];
                m_last  = r_last;
                s_ready = m_ready;
                if (m_ready) begin
                    w_state_next = s_valid ? HI : EMPTY;
                end
            end
            default: begin
                w_state_next = EMPTY;
            end
        endcase
    end

endmodule

// File: tb/tb_zuc_dw_down.sv
// tb_zuc_dw_down: directed and random stimulus against a word-queue reference model.
module tb_zuc_dw_down;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_last = 1'b0;
    logic [63:0] s_data = '0;
    logic        s_half = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    zuc_dw_down u_dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_last  (s_last),
        .s_data  (s_data),
`ifdef ZUC_DWD_ODD_EN
        .s_half  (s_half),
`endif
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .m_data  (m_data)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [32:0] exp_q[$];
    logic [32:0] out_word[$];
    int          out_cyc[$];
    int          in_cyc[$];
    logic        prev_stall = 1'b0;
    logic [33:0] prev_out = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: model words are {last, data}, upper word first, in acceptance order.
    always @(negedge clk) begin
        logic [32:0] e;
        logic        half_eff;
        if (!rstn) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("stall_hold", 64'({m_valid, m_last, m_data}), 64'(prev_out));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(m_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", 64'({m_last, m_data}), 64'(e));
                end
                out_word.push_back({m_last, m_data});
                out_cyc.push_back(cyc);
            end
            if (s_valid && s_ready) begin
`ifdef ZUC_DWD_ODD_EN
                half_eff = s_half;
`else
                half_eff = 1'b0;
`endif
                exp_q.push_back({s_last && half_eff, s_data[63:32]});
                if (!(s_last && half_eff)) exp_q.push_back({s_last, s_data[31:0]});
                in_cyc.push_back(cyc);
            end
            prev_stall = m_valid && !m_ready;
            prev_out   = {m_valid, m_last, m_data};
        end
    end

    task automatic put(input logic [63:0] d, input logic l, input logic h);
        logic hs;
        int   w;
        hs = 1'b0;
        w  = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        s_half  = h;
        while (!hs && w < 200) begin
            @(negedge clk);
            hs = s_ready;
            @(posedge clk);
            #1;
            w++;
        end
        if (!hs) chk("put_timeout", 64'(hs), 64'd1);
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int ibase;
        int guard;
        logic [63:0] d;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Single beat, latency and ordering
        m_ready = 1'b1;
        base  = out_cyc.size();
        ibase = in_cyc.size();
        put(64'h1111111122222222, 1'b1, 1'b0);
        idle(4);
        chk("t1_count", 64'(out_cyc.size() - base), 64'd2);
        if (out_cyc.size() >= base + 2 && in_cyc.size() > ibase) begin
            chk("t1_w0", 64'(out_word[base]), 64'({1'b0, 32'h11111111}));
            chk("t1_w1", 64'(out_word[base+1]), 64'({1'b1, 32'h22222222}));
            chk("t1_latency", 64'(out_cyc[base] - in_cyc[ibase]), 64'd1);
            chk("t1_consec", 64'(out_cyc[base+1] - out_cyc[base]), 64'd1);
        end

        // Four back-to-back beats: eight words, no bubble
        base  = out_cyc.size();
        ibase = in_cyc.size();
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            put(d, (i == 3), 1'b0);
        end
        idle(4);
        chk("t2_count", 64'(out_cyc.size() - base), 64'd8);
        if (out_cyc.size() >= base + 8 && in_cyc.size() >= ibase + 4) begin
            chk("t2_span", 64'(out_cyc[base+7] - out_cyc[base]), 64'd7);
            chk("t2_in_span", 64'(in_cyc[ibase+3] - in_cyc[ibase]), 64'd6);
            chk("t2_last7", 64'(out_word[base+7][32]), 64'd1);
            chk("t2_last6", 64'(out_word[base+6][32]), 64'd0);
        end

        // 100 random beats with 50% m_ready
        ibase = in_cyc.size();
        guard = 0;
        while (in_cyc.size() - ibase < 100 && guard < 5000) begin
            m_ready = 1'($urandom_range(0, 1));
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = {$urandom, $urandom};
            s_last  = ($urandom_range(0, 3) == 0);
            s_half  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            guard++;
        end
        s_valid = 1'b0;
        chk("rand_beats", 64'(in_cyc.size() - ibase), 64'd100);
        m_ready = 1'b1;
        idle(10);
        chk("rand_drain", 64'(exp_q.size()), 64'd0);

        // Reset while presenting the lower word
        put(64'hBBBBBBBBAAAAAAAA, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        chk("t4_lo_data", 64'(m_data), 64'hAAAAAAAA);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("t4_rst_valid", 64'(m_valid), 64'd0);
        chk("t4_rst_data", 64'(m_data), 64'd0);
        chk("t4_rst_ready", 64'(s_ready), 64'd1);
        rstn = 1'b1;
        m_ready = 1'b1;
        base = out_cyc.size();
        put(64'h0000000100000002, 1'b1, 1'b0);
        idle(4);
        chk("t4_count", 64'(out_cyc.size() - base), 64'd2);
        if (out_cyc.size() > base) chk("t4_first", 64'(out_word[base]), 64'({1'b0, 32'h00000001}));

`ifdef ZUC_DWD_ODD_EN
        // Half final beat followed immediately by a full beat
        base = out_cyc.size();
        put({32'h33333333, $urandom}, 1'b1, 1'b1);
        put(64'h4444444455555555, 1'b1, 1'b0);
        idle(4);
        chk("t5_count", 64'(out_cyc.size() - base), 64'd3);
        if (out_cyc.size() >= base + 3) begin
            chk("t5_w0", 64'(out_word[base]), 64'({1'b1, 32'h33333333}));
            chk("t5_w1", 64'(out_word[base+1]), 64'({1'b0, 32'h44444444}));
            chk("t5_w2", 64'(out_word[base+2]), 64'({1'b1, 32'h55555555}));
            chk("t5_span", 64'(out_cyc[base+2] - out_cyc[base]), 64'd2);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
